led_controller: RTL and testbench
=================================

// Module: led_controller
// PURPOSE
//  Serial driver for a WS2812-style chain of 8 RGB LEDs on one data wire.
//  Continuously refreshes the chain from eight 24-bit colour inputs.
//  Each refresh is a 192-bit frame followed by a latch gap.
//  Sits between host-written colour registers and the board's LED data pin.
// PARAMETERS
//  T0H_CYC  40    high time of a '0' bit, in clk cycles (0.40 us @100 MHz)
//  T1H_CYC  80    high time of a '1' bit, in clk cycles (0.80 us)
//  BIT_CYC  125   total bit period, in clk cycles (1.25 us); T1H_CYC < BIT_CYC
//  RST_CYC  5000  low latch gap between frames, in clk cycles (50 us)
// PORTS
//  clk      in   1   single system clock, 100 MHz nominal
//  reset    in   1   asynchronous, active-high reset
//  led1..8  in   24  colour word per LED; led1 is nearest the driver, sent first
//  dat_out  out  1   serial data to the LED chain; registered output
// BEHAVIOUR
//  - Reset (async, active-high): dat_out=0; FSM=GAP; all counters=0; shift reg=0.
//  - FSM is GAP -> LOAD -> SEND -> GAP, repeating forever.
//  - GAP: dat_out=0 for exactly RST_CYC cycles.
//  - LOAD: 1 cycle; dat_out=0.
//    Captures {led1,led2,...,led8} into a 192-bit shift register.
//    Input changes during SEND do not affect the frame in progress.
//  - SEND: 192 bits, MSB first: led1[23] first ... led8[0] last.
//  - Each bit lasts exactly BIT_CYC cycles:
//    dat_out=1 for T0H_CYC ('0') or T1H_CYC ('1') cycles, then 0 for the rest.
//  - Bit cycles follow back to back with no idle between bits.
//  - After bit 191 completes, the FSM returns to GAP.
//  - Frame length is 192*BIT_CYC = 24000 cycles; full period is 29001 cycles.
//  - Timing after reset release (first rising clk edge with reset low = edge 1):
//    dat_out first goes high at edge RST_CYC+2.
//  - Reset asserted mid-frame: dat_out drops to 0 immediately (async).
//    After release the FSM restarts at GAP; no partial frame resumes.
//  - Counters are sized by $clog2 of their parameter.
//    The bit counter runs 0..191 and never wraps mid-frame.
// CONFIGURATION
//  LED_CONTROLLER_RGB_TO_GRB_EN
//  - Defined: each ledN is read as {R[23:16],G[15:8],B[7:0]}.
//    It is reordered to {G,R,B} at LOAD, matching native WS2812 order.
//  - Undefined: ledN is transmitted verbatim; the caller packs GRB.
//  - Timing and frame length are identical in both builds.
// STRUCTURE
//  - Package led_controller_pkg holds:
//    default timing constants (T0H/T1H/BIT/RST);
//    NUM_LEDS=8 and FRAME_BITS=192;
//    FSM state typedef {GAP, LOAD, SEND}.
//  - Sub-module ws2812_bit_encoder (one instance):
//    inputs start, bit_val; outputs dout, done.
//    Generates one BIT_CYC waveform; done pulses in its last cycle.
//  - Top level holds the FSM, the gap counter, the shift register and the bit counter.
// TESTING
//  - Reset held 100 ns, then released with led1=24'h01FFFF, others 0:
//    dat_out stays 0 through the gap;
//    first bits are 7x'0' (40 hi/85 lo) then 17x'1' (80 hi/45 lo);
//    then 168x'0'.
//  - All inputs 24'hFFFFFF: 192 consecutive 80-cycle pulses, then 5001 cycles low, then repeat.
//  - Change led8 mid-frame: the current frame keeps the old value;
//    the next frame carries the new value.
//  - Assert reset during bit 50: dat_out=0 at once;
//    after release, exactly RST_CYC+1 low cycles precede the first pulse.
//  - With LED_CONTROLLER_RGB_TO_GRB_EN, led1=24'hFF0000:
//    first byte sent is 8'h00, second is 8'hFF.
//    Without the macro, the first byte sent is 8'hFF.
//  - Checker measures every high and low interval of dat_out:
//    each bit period is exactly 125 cycles;
//    no glitches and no X after reset.

Source files
------------

// File: rtl/led_controller_pkg.sv
// Shared constants, FSM state type and colour helper for led_controller.
// Default WS2812 timings assume a 100 MHz clock.
package led_controller_pkg;

   localparam int DEF_T0H_CYC = 40;
   localparam int DEF_T1H_CYC = 80;
   localparam int DEF_BIT_CYC = 125;
   localparam int DEF_RST_CYC = 5000;

   localparam int NUM_LEDS   = 8;
   localparam int LED_BITS   = 24;
   localparam int FRAME_BITS = NUM_LEDS * LED_BITS;

   typedef enum logic [1:0] {
      GAP  = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   // Host colour word {R,G,B} to the chain's native {G,R,B} order.
   function automatic logic [LED_BITS-1:0] rgb_to_grb(
      input logic [LED_BITS-1:0] c
   );
      return {c[15:8], c[23:16], c[7:0]};
   endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit cell: a high pulse of T0H/T1H cycles inside a
// BIT_CYC-cycle period. start may be asserted in the done cycle to chain bits.
module ws2812_bit_encoder #(
   parameter int T0H_CYC = 40,
   parameter int T1H_CYC = 80,
   parameter int BIT_CYC = 125
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic bit_val,
   output logic dout,
   output logic done
);

   localparam int CW = $clog2(BIT_CYC);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

   logic          busy;
   logic          val;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] hi_len;

   // Next phase count and high time of the bit being sent.
   always_comb begin
      cnt_nxt = cnt + CW'(1);
      hi_len  = val ? T1H : T0H;
   end

   assign done = busy && (cnt == LAST);

   // Phase counter and registered output; output rises on the start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0;
         val  <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         val  <= bit_val;
         cnt  <= '0;
         dout <= 1'b1;
      end else if (busy) begin
         if (cnt == LAST) begin
            busy <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
         end else begin
            cnt  <= cnt_nxt;
            dout <= (cnt_nxt < hi_len);
         end
      end
   end

endmodule

// File: rtl/led_controller.sv
// WS2812 chain driver: 8 LEDs refreshed forever as GAP -> LOAD -> SEND.
// Optional macro LED_CONTROLLER_RGB_TO_GRB_EN reorders {R,G,B} to {G,R,B}.
module led_controller
   import led_controller_pkg::*;
#(
   parameter int T0H_CYC = DEF_T0H_CYC,
   parameter int T1H_CYC = DEF_T1H_CYC,
   parameter int BIT_CYC = DEF_BIT_CYC,
   parameter int RST_CYC = DEF_RST_CYC
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [LED_BITS-1:0] led1,
   input  logic [LED_BITS-1:0] led2,
   input  logic [LED_BITS-1:0] led3,
   input  logic [LED_BITS-1:0] led4,
   input  logic [LED_BITS-1:0] led5,
   input  logic [LED_BITS-1:0] led6,
   input  logic [LED_BITS-1:0] led7,
   input  logic [LED_BITS-1:0] led8,
   output logic                dat_out
);

   localparam int GW = $clog2(RST_CYC + 1);
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [GW-1:0] GAP_END  = GW'(RST_CYC);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

   state_t state;
   state_t state_nxt;

   logic [GW-1:0]         gap_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic [FRAME_BITS-1:0] frame;
   logic [LED_BITS-1:0]   leds [NUM_LEDS];

   logic start;
   logic bit_val;
   logic enc_done;
   logic last_bit;

   assign leds[0] = led1;
   assign leds[1] = led2;
   assign leds[2] = led3;
   assign leds[3] = led4;
   assign leds[4] = led5;
   assign leds[5] = led6;
   assign leds[6] = led7;
   assign leds[7] = led8;

   assign last_bit = (bit_cnt == LAST_BIT);

   // Assemble the frame, led1 in the top bits so it goes out first.
   always_comb begin
      frame = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_CONTROLLER_RGB_TO_GRB_EN
         frame[FRAME_BITS-1-i*LED_BITS -: LED_BITS] = rgb_to_grb(leds[i]);
`else
         frame[FRAME_BITS-1-i*LED_BITS -: LED_BITS] = leds[i];
`endif
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= GAP;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         GAP:  if (gap_cnt == GAP_END) state_nxt = LOAD;
         LOAD: state_nxt = SEND;
         SEND: if (enc_done && last_bit) state_nxt = GAP;
         default: state_nxt = GAP;
      endcase
   end

   // Encoder kick: first bit from the live frame in LOAD, then chain on done.
   always_comb begin
      start   = 1'b0;
      bit_val = 1'b0;
      unique case (state)
         LOAD: begin
            start   = 1'b1;
            bit_val = frame[FRAME_BITS-1];
         end
         SEND: begin
            start   = enc_done && !last_bit;
            bit_val = shift[FRAME_BITS-1];
         end
         default: begin
            start   = 1'b0;
            bit_val = 1'b0;
         end
      endcase
   end

   // Gap counter, bit counter and shift register (holds the bits still to go).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         unique case (state)
            GAP: begin
               if (gap_cnt == GAP_END) gap_cnt <= '0;
               else gap_cnt <= gap_cnt + GW'(1);
            end
            LOAD: begin
               shift   <= {frame[FRAME_BITS-2:0], 1'b0};
               bit_cnt <= '0;
            end
            SEND: begin
               if (enc_done) begin
                  shift <= {shift[FRAME_BITS-2:0], 1'b0};
                  if (last_bit) begin
                     bit_cnt <= '0;
                     // The cycle spent in the final bit's done counts toward the gap.
                     gap_cnt <= GW'(1);
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            default: begin
               gap_cnt <= '0;
            end
         endcase
      end
   end

   ws2812_bit_encoder #(
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .BIT_CYC (BIT_CYC)
   ) u_enc (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bit_val (bit_val),
      .dout    (dat_out),
      .done    (enc_done)
   );

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: cycle-exact waveform model
// derived from frame timing, plus pulse decoding of the serial stream.
module tb_led_controller;
   import led_controller_pkg::*;

   localparam int unsigned T0H    = DEF_T0H_CYC;
   localparam int unsigned T1H    = DEF_T1H_CYC;
   localparam int unsigned BITC   = DEF_BIT_CYC;
   localparam int unsigned RSTC   = DEF_RST_CYC;
   localparam int unsigned FRAMEC = FRAME_BITS * DEF_BIT_CYC;
   localparam int unsigned PERIOD = FRAMEC + RSTC + 1;
   localparam int unsigned FIRST  = RSTC + 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [23:0] led1, led2, led3, led4, led5, led6, led7, led8;
   logic dat_out;

   always #5 clk = ~clk;

   led_controller dut (
      .clk     (clk),
      .reset   (reset),
      .led1    (led1),
      .led2    (led2),
      .led3    (led3),
      .led4    (led4),
      .led5    (led5),
      .led6    (led6),
      .led7    (led7),
      .led8    (led8),
      .dat_out (dat_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0]  cur [8];
   logic [191:0] frames [$];
   logic         rx [$];
   int unsigned  n;
   int unsigned  first_rise;
   int unsigned  hi_len;
   logic         prev;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic [23:0] sent_word(input logic [23:0] w);
`ifdef LED_CONTROLLER_RGB_TO_GRB_EN
      return {w[15:8], w[23:16], w[7:0]};
`else
      return w;
`endif
   endfunction

   // Expected line level just after edge k of the current epoch.
   function automatic logic model(input int unsigned k);
      int unsigned d, f, r, b, ph;
      logic [23:0] w;
      logic bv;
      if (k < FIRST) return 1'b0;
      d = k - FIRST;
      f = d / PERIOD;
      r = d % PERIOD;
      if (r >= FRAMEC) return 1'b0;
      if (f >= frames.size()) return 1'bx;
      b  = r / BITC;
      ph = r % BITC;
      w  = sent_word(frames[f][191 - (b/24)*24 -: 24]);
      bv = w[23 - (b % 24)];
      return (ph < (bv ? T1H : T0H));
   endfunction

   task automatic set_leds();
      led1 = cur[0]; led2 = cur[1]; led3 = cur[2]; led4 = cur[3];
      led5 = cur[4]; led6 = cur[5]; led7 = cur[6]; led8 = cur[7];
   endtask

   task automatic begin_epoch();
      n = 0;
      frames.delete();
      rx.delete();
      prev = 1'b0;
      hi_len = 0;
      first_rise = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      n++;
      if (n >= FIRST && ((n - FIRST) % PERIOD) == 0)
         frames.push_back({cur[0], cur[1], cur[2], cur[3],
                           cur[4], cur[5], cur[6], cur[7]});
      #1;
      check("dat", dat_out, model(n));
      if (dat_out === 1'b1) begin
         if (prev !== 1'b1 && first_rise == 0) first_rise = n;
         hi_len++;
      end else if (prev === 1'b1) begin
         check("pulse_w", (hi_len == T0H || hi_len == T1H), 1);
         rx.push_back(hi_len == T1H);
         hi_len = 0;
      end
      prev = dat_out;
   endtask

   task automatic run_to(input int unsigned target);
      while (n < target) tick();
   endtask

   initial begin
      logic [23:0] w;
      logic [7:0]  by;
      int          ones;

      n = 0;
      for (int i = 0; i < 8; i++) cur[i] = 24'h0;
      cur[0] = 24'h01FFFF;
      set_leds();
      reset = 1'b1;
      #100;
      #1 check("rst_dat", dat_out, 0);
      @(negedge clk);
      reset = 1'b0;
      begin_epoch();

      run_to(FIRST + 100*BITC);
      check("first_rise", first_rise, FIRST);
      w = '0;
      for (int i = 0; i < 24; i++) w = {w[22:0], rx[i]};
      check("first_word", w, sent_word(24'h01FFFF));

      for (int i = 0; i < 8; i++) cur[i] = 24'hFFFFFF;
      set_leds();

      run_to(FIRST + PERIOD + 120*BITC + 3);
      ones = 0;
      for (int i = 0; i < 192; i++) ones += int'(rx[i]);
      check("frame0_ones", ones, $countones(sent_word(24'h01FFFF)));
      ones = 0;
      for (int i = 192; i < 312; i++) ones += int'(rx[i]);
      check("ff_ones", ones, 120);

      for (int i = 0; i < 8; i++) cur[i] = 24'($urandom);
      set_leds();

      run_to(FIRST + 2*PERIOD + 50*BITC + 10);
      #2 reset = 1'b1;
      #1 check("async_rst", dat_out, 0);
      repeat (10) begin
         @(posedge clk);
         #1 check("hold_rst", dat_out, 0);
      end

      cur[0] = 24'hFF0000;
      for (int i = 1; i < 8; i++) cur[i] = 24'($urandom);
      set_leds();
      @(negedge clk);
      reset = 1'b0;
      begin_epoch();

      run_to(FIRST + 16*BITC + 5);
      check("rise_after_rst", first_rise, FIRST);
      by = '0;
      for (int i = 0; i < 8; i++) by = {by[6:0], rx[i]};
`ifdef LED_CONTROLLER_RGB_TO_GRB_EN
      check("first_byte", by, 8'h00);
`else
      check("first_byte", by, 8'hFF);
`endif
      by = '0;
      for (int i = 8; i < 16; i++) by = {by[6:0], rx[i]};
`ifdef LED_CONTROLLER_RGB_TO_GRB_EN
      check("second_byte", by, 8'hFF);
`else
      check("second_byte", by, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
